chirp_sequencer: RTL and testbench
==================================

Name: chirp_sequencer

Overview:
- Plays a programmed list of chirp profiles into the dds_chirp datapath by driving its start, freq, delta_freq and delta_rate inputs.
- Holds an N-entry profile table. On a trigger it plays entries seq_first..seq_last, repeats the list seq_repeat times, and inserts a programmable gap between chirps.
- Sits between the control/register interface and the DDS chirp generator.

Parameters:
N_PROF, 8, number of profile table entries (power of 2)
CNT_W, 32, width of the length and gap counters
MIN_GAP, 2, minimum low time on dds_start between chirps, required by the DDS rising-edge detector

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  profile table write strobe
cfg_addr  in  $clog2(N_PROF)  profile index to write
cfg_freq  in  48  start phase increment
cfg_dfreq  in  48  phase-increment step
cfg_drate  in  32  step interval, in DDS units
cfg_len  in  CNT_W  chirp length in clocks
cfg_gap  in  CNT_W  gap after the chirp in clocks
seq_first  in  $clog2(N_PROF)  first entry index
seq_last  in  $clog2(N_PROF)  last entry index
seq_repeat  in  16  list passes; 0 = run until abort
trig  in  1  start the sequence (level, sampled only in IDLE)
abort  in  1  stop immediately
dds_start  out  1  to DDS start
dds_freq  out  48  to DDS_freq
dds_delta_freq  out  48  to DDS_delta_freq
dds_delta_rate  out  32  to DDS_delta_rate
cur_idx  out  $clog2(N_PROF)  entry currently playing
busy  out  1  sequence active
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset: all outputs 0, state IDLE, table contents undefined. Reset mid-chirp drops dds_start asynchronously.
- States and transitions:
  - IDLE: on trig=1 with seq_first<=seq_last, go to LOAD, busy=1, idx=seq_first, pass=1.
  - LOAD (1 cycle): register the table[idx] fields onto the dds_* buses; dds_start=0; go to ON.
  - ON: dds_start=1 for exactly max(len,1) cycles.
  - GAP: dds_start=0 for max(gap,MIN_GAP) cycles. Then:
    - if idx<seq_last, idx+1 and go to LOAD;
    - else if seq_repeat==0 or pass<seq_repeat, idx=seq_first, pass+1, go to LOAD;
    - else go to DONE.
  - DONE (1 cycle): done=1, busy=0, dds_* parameter buses cleared to 0; go to IDLE.
- Latency: trig sampled high at edge T gives LOAD at T+1, with dds_start rising at edge T+2.
- Parameter stability: dds_freq, dds_delta_freq and dds_delta_rate stay constant from LOAD through the end of the following GAP. The DDS samples them at any time while start is high.
- Low time between consecutive chirps is the clamped gap + 1 (the LOAD cycle).
- trig while busy: ignored, no err.
- trig in IDLE with seq_first>seq_last: err pulse, stay IDLE.
- cfg_we while busy: write dropped, err pulse. cfg_we in IDLE: write lands in 1 cycle. Write and trig in the same IDLE cycle: write lands first and LOAD sees the new data.
- abort (any state): next cycle state=IDLE, dds_start=0, parameter buses=0, busy=0, no done. abort wins over trig in the same cycle.
- seq_first, seq_last and seq_repeat are latched at trig; later changes have no effect until the next trig.
- Counters are CNT_W wide and count down to 1. A length or gap of 2^CNT_W-1 is legal.
- The pass counter is 16 bits and is not compared when seq_repeat==0.

Decomposition:
- chirp_pkg: state enum (IDLE, LOAD, ON, GAP, DONE); struct chirp_prof_t {freq 48, dfreq 48, drate 32, len CNT_W, gap CNT_W}; constant MIN_GAP.
- Sub-module chirp_prof_ram: N_PROF×chirp_prof_t, synchronous write, registered read addressed by idx. The read is issued in GAP/IDLE so that data is valid in LOAD.

Test Plan:
- Entry0 = {freq 1000, dfreq 10, drate 3, len 20, gap 5}, first=last=0, repeat=1, trig -> dds_start rises 2 cycles after trig, high 20, low 5; done pulse once; dds_freq=1000 throughout ON.
- Entries 0..2 with len 4/6/8 and gap 0, repeat=2 -> start pattern 4H,3L,6H,3L,8H,3L, then repeat; exactly 6 rising edges; cur_idx sequence 0,1,2,0,1,2.
- repeat=0, abort asserted mid-ON of the 5th chirp -> dds_start=0 and busy=0 on the next cycle, buses=0, no done pulse.
- trig with first=3, last=1 -> err pulse, dds_start stays 0, busy stays 0. cfg_we during busy -> err pulse, and a table readback after completion shows the old value.
- rst_n asserted mid-chirp -> dds_start=0 with no clock edge, all outputs 0. trig after release runs a normal sequence.
- len=0, gap=1 -> dds_start high 1 cycle, low MIN_GAP+1=3 cycles between chirps.

Source files
------------

// File: rtl/chirp_pkg.sv
// Shared types and constants for the chirp sequencer: FSM encodings,
// the profile table entry layout and the minimum inter-chirp low time.
// No logic; no latency or backpressure of its own.
package chirp_pkg;
    localparam int CNT_W   = 32;
    localparam int MIN_GAP = 2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ON   = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef struct packed {
        logic [47:0]      freq;
        logic [47:0]      dfreq;
        logic [31:0]      drate;
        logic [CNT_W-1:0] len;
        logic [CNT_W-1:0] gap;
    } chirp_prof_t;
endpackage

// File: rtl/chirp_sequencer_if.sv
// Control/config side and DDS side of the chirp sequencer in one bundle.
// Master drives config/commands; slave (the sequencer) drives DDS and status.
// No flow control: commands are level/strobe sampled, status is pulsed.
interface chirp_sequencer_if #(
    parameter int N_PROF = 8,
    parameter int CNT_W  = 32
);
    localparam int AW = $clog2(N_PROF);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [47:0]      cfg_freq;
    logic [47:0]      cfg_dfreq;
    logic [31:0]      cfg_drate;
    logic [CNT_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_gap;
    logic [AW-1:0]    seq_first;
    logic [AW-1:0]    seq_last;
    logic [15:0]      seq_repeat;
    logic             trig;
    logic             abort;
    logic             dds_start;
    logic [47:0]      dds_freq;
    logic [47:0]      dds_delta_freq;
    logic [31:0]      dds_delta_rate;
    logic [AW-1:0]    cur_idx;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cfg_we, cfg_addr, cfg_freq, cfg_dfreq, cfg_drate, cfg_len, cfg_gap,
        output seq_first, seq_last, seq_repeat, trig, abort,
        input  dds_start, dds_freq, dds_delta_freq, dds_delta_rate,
        input  cur_idx, busy, done, err
    );
    modport slave (
        input  cfg_we, cfg_addr, cfg_freq, cfg_dfreq, cfg_drate, cfg_len, cfg_gap,
        input  seq_first, seq_last, seq_repeat, trig, abort,
        output dds_start, dds_freq, dds_delta_freq, dds_delta_rate,
        output cur_idx, busy, done, err
    );
endinterface

// File: rtl/chirp_prof_ram.sv
// Profile table: synchronous write, registered read with write-through bypass.
// Latency: read data valid one cycle after rd_vld; holds until the next read.
// No backpressure: every write and read strobe is accepted.
module chirp_prof_ram
    import chirp_pkg::*;
#(
    parameter int N_PROF = 8,
    parameter int AW     = $clog2(N_PROF)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  chirp_prof_t wr_dat,
    input  logic        rd_vld,
    input  logic [AW-1:0] rd_addr,
    output chirp_prof_t rd_dat
);
    chirp_prof_t mem_q [N_PROF];
    chirp_prof_t rd_dat_d, rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_vld) mem_q[wr_addr] <= wr_dat;
    end

    // Bypass lets a write and a trigger in the same cycle load the new entry.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_vld) rd_dat_d = (wr_vld && wr_addr == rd_addr) ? wr_dat : mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_dat_q <= '0;
        else        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;
endmodule

// File: rtl/chirp_sequencer.sv
// Plays table entries seq_first..seq_last into the DDS, repeated, with gaps.
// Latency: trig at edge T -> LOAD at T+1, dds_start rises at edge T+2.
// No backpressure: trig while busy is ignored; cfg writes while busy are dropped with err.
module chirp_sequencer #(
    parameter int N_PROF  = 8,
    parameter int CNT_W   = 32,
    parameter int MIN_GAP = 2
) (
    input  logic clk,
    input  logic rst_n,
    chirp_sequencer_if.slave bus
);
    import chirp_pkg::*;

    localparam int AW = $clog2(N_PROF);

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d, first_q, first_d, last_q, last_d;
    logic [15:0]      pass_q, pass_d, rep_q, rep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             active, trig_ok, wr_ok, rd_vld;
    logic [CNT_W-1:0] len_c, gap_c;
    chirp_prof_t      wr_dat, prof;

    assign active  = (state_q == ST_LOAD) || (state_q == ST_ON) || (state_q == ST_GAP);
    assign trig_ok = (state_q == ST_IDLE) && bus.trig && !bus.abort;
    assign wr_ok   = bus.cfg_we && !active;
    assign wr_dat  = {bus.cfg_freq, bus.cfg_dfreq, bus.cfg_drate, bus.cfg_len, bus.cfg_gap};

    assign len_c = (prof.len == '0) ? CNT_W'(1) : CNT_W'(prof.len);
    assign gap_c = (CNT_W'(prof.gap) < CNT_W'(MIN_GAP)) ? CNT_W'(MIN_GAP) : CNT_W'(prof.gap);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        first_d = first_q;
        last_d  = last_q;
        pass_d  = pass_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        err_d   = (bus.cfg_we && active) || (trig_ok && (bus.seq_first > bus.seq_last));
        case (state_q)
            ST_IDLE: begin
                if (trig_ok && (bus.seq_first <= bus.seq_last)) begin
                    state_d = ST_LOAD;
                    idx_d   = bus.seq_first;
                    first_d = bus.seq_first;
                    last_d  = bus.seq_last;
                    rep_d   = bus.seq_repeat;
                    pass_d  = 16'd1;
                end
            end
            ST_LOAD: begin
                state_d = ST_ON;
                cnt_d   = len_c;
            end
            ST_ON: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_GAP;
                    cnt_d   = gap_c;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q != CNT_W'(1)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q < last_q) begin
                    state_d = ST_LOAD;
                    idx_d   = idx_q + 1'b1;
                end else if (rep_q == 16'd0 || pass_q < rep_q) begin
                    state_d = ST_LOAD;
                    idx_d   = first_q;
                    pass_d  = pass_q + 16'd1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort) state_d = ST_IDLE;
    end

    // Table read is issued on the edge into LOAD so the entry is valid during LOAD.
    assign rd_vld = (state_d == ST_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            pass_q  <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            last_q  <= last_d;
            pass_q  <= pass_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    chirp_prof_ram #(.N_PROF(N_PROF), .AW(AW)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_vld  (wr_ok),
        .wr_addr (bus.cfg_addr),
        .wr_dat  (wr_dat),
        .rd_vld  (rd_vld),
        .rd_addr (idx_d),
        .rd_dat  (prof)
    );

    assign bus.dds_start      = (state_q == ST_ON);
    assign bus.dds_freq       = active ? prof.freq  : '0;
    assign bus.dds_delta_freq = active ? prof.dfreq : '0;
    assign bus.dds_delta_rate = active ? prof.drate : '0;
    assign bus.cur_idx        = idx_q;
    assign bus.busy           = active;
    assign bus.done           = (state_q == ST_DONE);
    assign bus.err            = err_q;
endmodule

// File: tb/tb_chirp_sequencer.sv
// Bench for chirp_sequencer: cycle traces are built from a table model and
// the sequencing rules, then compared against the DUT outputs each cycle.
module tb_chirp_sequencer;
    localparam int NP = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    chirp_sequencer_if #(.N_PROF(NP), .CNT_W(32)) bus();
    chirp_sequencer #(.N_PROF(NP), .CNT_W(32), .MIN_GAP(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [47:0] m_freq  [NP];
    logic [47:0] m_dfreq [NP];
    logic [31:0] m_drate [NP];
    logic [31:0] m_len   [NP];
    logic [31:0] m_gap   [NP];

    typedef struct {
        logic         s;
        logic         b;
        logic         d;
        logic [127:0] p;
        int           idx;
    } exp_t;

    function automatic logic [127:0] pbus(input int i);
        return {m_freq[i], m_dfreq[i], m_drate[i]};
    endfunction

    function automatic logic [127:0] obus();
        return {bus.dds_freq, bus.dds_delta_freq, bus.dds_delta_rate};
    endfunction

    task automatic idle_inputs();
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_freq = 0; bus.cfg_dfreq = 0;
        bus.cfg_drate = 0; bus.cfg_len = 0; bus.cfg_gap = 0;
        bus.seq_first = 0; bus.seq_last = 0; bus.seq_repeat = 0;
        bus.trig = 0; bus.abort = 0;
    endtask

    task automatic stage_write(input int a, input logic [47:0] f, input logic [47:0] df,
                               input logic [31:0] dr, input logic [31:0] ln, input logic [31:0] gp);
        bus.cfg_we = 1; bus.cfg_addr = 3'(a); bus.cfg_freq = f; bus.cfg_dfreq = df;
        bus.cfg_drate = dr; bus.cfg_len = ln; bus.cfg_gap = gp;
        m_freq[a] = f; m_dfreq[a] = df; m_drate[a] = dr; m_len[a] = ln; m_gap[a] = gp;
    endtask

    task automatic write_prof(input int a, input logic [47:0] f, input logic [47:0] df,
                              input logic [31:0] dr, input logic [31:0] ln, input logic [31:0] gp);
        stage_write(a, f, df, dr, ln, gp);
        @(negedge clk);
        bus.cfg_we = 0;
    endtask

    // Builds the expected per-cycle trace of a whole sequence and walks it.
    task automatic run_seq(input string nm, input int f0, input int l0, input int rep);
        exp_t q[$];
        exp_t e;
        for (int p = 0; p < rep; p++) begin
            for (int i = f0; i <= l0; i++) begin
                int hi = (m_len[i] == 0) ? 1 : int'(m_len[i]);
                int lo = (m_gap[i] < 2) ? 2 : int'(m_gap[i]);
                e.s = 0; e.b = 1; e.d = 0; e.p = pbus(i); e.idx = i;
                q.push_back(e);
                e.s = 1;
                for (int k = 0; k < hi; k++) q.push_back(e);
                e.s = 0;
                for (int k = 0; k < lo; k++) q.push_back(e);
            end
        end
        e.s = 0; e.b = 0; e.d = 1; e.p = '0; e.idx = -1;
        q.push_back(e);
        e.d = 0;
        q.push_back(e);

        bus.seq_first = 3'(f0); bus.seq_last = 3'(l0); bus.seq_repeat = 16'(rep);
        bus.trig = 1;
        @(negedge clk);
        bus.trig = 0; bus.cfg_we = 0;
        bus.seq_first = 3'($urandom); bus.seq_last = 3'($urandom); bus.seq_repeat = 16'($urandom);
        foreach (q[k]) begin
            checks++;
            if ({bus.dds_start, bus.busy, bus.done, bus.err} !== {q[k].s, q[k].b, q[k].d, 1'b0}) begin
                errors++;
                $display("FAIL %s cyc %0d start/busy/done/err got %b want %b", nm, k,
                         {bus.dds_start, bus.busy, bus.done, bus.err}, {q[k].s, q[k].b, q[k].d, 1'b0});
            end
            checks++;
            if (obus() !== q[k].p) begin
                errors++;
                $display("FAIL %s cyc %0d dds buses got %h want %h", nm, k, obus(), q[k].p);
            end
            if (q[k].idx >= 0) begin
                checks++;
                if (bus.cur_idx !== 3'(q[k].idx)) begin
                    errors++;
                    $display("FAIL %s cyc %0d cur_idx got %0d want %0d", nm, k, bus.cur_idx, q[k].idx);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #1;
        checks++;
        if ({bus.dds_start, bus.busy, bus.done, bus.err, bus.cur_idx, obus()} !== '0) begin
            errors++;
            $display("FAIL reset outputs got start=%b busy=%b done=%b err=%b idx=%0d bus=%h want all 0",
                     bus.dds_start, bus.busy, bus.done, bus.err, bus.cur_idx, obus());
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        write_prof(0, 48'd1000, 48'd10, 32'd3, 32'd20, 32'd5);
        run_seq("single", 0, 0, 1);
    endtask

    task automatic test_list();
        write_prof(0, 48'h111, 48'd1, 32'd1, 32'd4, 32'd0);
        write_prof(1, 48'h222, 48'd2, 32'd2, 32'd6, 32'd0);
        write_prof(2, 48'h333, 48'd3, 32'd3, 32'd8, 32'd0);
        run_seq("list", 0, 2, 2);
    endtask

    task automatic test_min_gap();
        write_prof(3, 48'hA5A5, 48'd7, 32'd9, 32'd0, 32'd1);
        write_prof(4, 48'h5A5A, 48'd8, 32'd4, 32'd0, 32'd1);
        run_seq("min_gap", 3, 4, 1);
    endtask

    task automatic test_write_trig();
        write_prof(5, 48'h1, 48'h1, 32'h1, 32'd2, 32'd2);
        stage_write(5, 48'hFEED_0000_BEEF, 48'h77, 32'h99, 32'd3, 32'd4);
        run_seq("write_trig", 5, 5, 1);
    endtask

    task automatic test_err();
        bit seen = 0;
        bus.seq_first = 3; bus.seq_last = 1; bus.seq_repeat = 1; bus.trig = 1;
        @(negedge clk);
        bus.trig = 0;
        checks++;
        if ({bus.err, bus.busy, bus.dds_start} !== 3'b100) begin
            errors++;
            $display("FAIL bad_range err/busy/start got %b want 100", {bus.err, bus.busy, bus.dds_start});
        end
        @(negedge clk);
        checks++;
        if ({bus.err, bus.busy, bus.dds_start} !== 3'b000) begin
            errors++;
            $display("FAIL bad_range_after err/busy/start got %b want 000", {bus.err, bus.busy, bus.dds_start});
        end

        write_prof(0, 48'h0ABC, 48'd5, 32'd6, 32'd30, 32'd2);
        bus.seq_first = 0; bus.seq_last = 0; bus.seq_repeat = 1; bus.trig = 1;
        @(negedge clk);
        bus.trig = 0;
        repeat (5) @(negedge clk);
        bus.cfg_we = 1; bus.cfg_addr = 0; bus.cfg_freq = 48'hDEAD_BEEF;
        bus.cfg_len = 32'd1; bus.cfg_gap = 32'd1;
        @(negedge clk);
        bus.cfg_we = 0;
        checks++;
        if ({bus.err, bus.busy} !== 2'b11) begin
            errors++;
            $display("FAIL busy_write err/busy got %b want 11", {bus.err, bus.busy});
        end
        for (int c = 0; c < 100 && !seen; c++) begin
            if (bus.done) seen = 1;
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL busy_write_done done seen %b want 1", seen);
        end
        run_seq("readback", 0, 0, 1);
    endtask

    task automatic test_abort();
        int  rises = 0;
        bit  prev = 0, hit = 0, done_seen = 0;
        write_prof(0, 48'h100, 48'd1, 32'd1, 32'd3, 32'd2);
        write_prof(1, 48'h200, 48'd2, 32'd2, 32'd3, 32'd2);
        bus.seq_first = 0; bus.seq_last = 1; bus.seq_repeat = 0; bus.trig = 1;
        @(negedge clk);
        bus.trig = 0;
        for (int c = 0; c < 400 && !hit; c++) begin
            if (bus.done) done_seen = 1;
            if (bus.dds_start && !prev) rises++;
            prev = bus.dds_start;
            if (rises == 5 && bus.dds_start) hit = 1;
            @(negedge clk);
        end
        checks++;
        if (!hit || bus.dds_start !== 1'b1 || done_seen) begin
            errors++;
            $display("FAIL abort_setup reached %b start %b done %b want 1 1 0", hit, bus.dds_start, done_seen);
        end
        bus.abort = 1;
        @(negedge clk);
        bus.abort = 0;
        checks++;
        if ({bus.dds_start, bus.busy, bus.done, obus()} !== '0) begin
            errors++;
            $display("FAIL abort start/busy/done got %b%b%b bus %h want 0", bus.dds_start, bus.busy, bus.done, obus());
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({bus.dds_start, bus.busy, bus.done} !== 3'b000) begin
                errors++;
                $display("FAIL abort_after start/busy/done got %b want 000", {bus.dds_start, bus.busy, bus.done});
            end
        end
        bus.seq_first = 0; bus.seq_last = 0; bus.seq_repeat = 1; bus.trig = 1; bus.abort = 1;
        @(negedge clk);
        bus.trig = 0; bus.abort = 0;
        repeat (2) begin
            checks++;
            if ({bus.busy, bus.dds_start, bus.err} !== 3'b000) begin
                errors++;
                $display("FAIL abort_vs_trig busy/start/err got %b want 000", {bus.busy, bus.dds_start, bus.err});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        write_prof(0, 48'h4242, 48'd3, 32'd2, 32'd10, 32'd2);
        bus.seq_first = 0; bus.seq_last = 0; bus.seq_repeat = 1; bus.trig = 1;
        @(negedge clk);
        bus.trig = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.dds_start !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_setup start got %b want 1", bus.dds_start);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({bus.dds_start, bus.busy, bus.done, bus.err, bus.cur_idx, obus()} !== '0) begin
            errors++;
            $display("FAIL async_reset outputs got start=%b busy=%b idx=%0d bus=%h want all 0",
                     bus.dds_start, bus.busy, bus.cur_idx, obus());
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        write_prof(0, 48'h9999, 48'd4, 32'd5, 32'd3, 32'd3);
        run_seq("post_reset", 0, 0, 1);
    endtask

    task automatic test_random();
        logic [63:0] r1, r2;
        for (int it = 0; it < 4; it++) begin
            int a, b;
            for (int i = 0; i < NP; i++) begin
                r1 = {$urandom, $urandom};
                r2 = {$urandom, $urandom};
                write_prof(i, r1[47:0], r2[47:0], $urandom, 32'($urandom_range(0, 6)), 32'($urandom_range(0, 5)));
            end
            a = $urandom_range(0, NP - 1);
            b = $urandom_range(0, NP - 1);
            if (a > b) begin int t = a; a = b; b = t; end
            run_seq($sformatf("random%0d", it), a, b, $urandom_range(1, 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_list();
        test_min_gap();
        test_write_trig();
        test_err();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
